// File: rtl/note_scheduler.sv
// Chart reader: walks the note ROM in order and issues one spawn handshake per note once
// its timestamp falls within LEAD frames of the game timer.
module note_scheduler #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [15:0] LEAD   = 16'd60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_sign,
  input  logic              stop_sign,
  input  logic [15:0]       un_time,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [19:0]       rom_data,
  output logic              spawn_valid,
  output logic [3:0]        spawn_lane,
  output logic [15:0]       spawn_time,
  input  logic              spawn_ready,
  output logic              chart_done,
  output logic [ADDR_W:0]   note_count
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWait,
    StEmit,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] AddrMax   = '1;
  localparam logic [ADDR_W-1:0] AddrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CountOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [15:0]       TermStamp = 16'hFFFF;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [3:0]        lane_q, lane_d;
  logic [15:0]       time_q, time_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [16:0] deadline;
  logic        due;
  logic        accept;

  // 17-bit sum so a timer near 16'hFFFF plus LEAD cannot wrap and hide a due note.
  assign deadline = {1'b0, un_time} + {1'b0, LEAD};
  assign due      = ({1'b0, time_q} <= deadline);
  assign accept   = valid_q && spawn_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    lane_d  = lane_q;
    time_d  = time_q;

    unique case (state_q)
      StIdle: begin
        addr_d  = '0;
        count_d = '0;
        if (start_sign) state_d = StFetch;
      end
      StFetch: begin
        state_d = stop_sign ? StDone : StLoad;
      end
      StLoad: begin
        if (stop_sign) begin
          state_d = StDone;
        end else begin
          lane_d  = rom_data[19:16];
          time_d  = rom_data[15:0];
          state_d = (rom_data[15:0] == TermStamp) ? StDone : StWait;
        end
      end
      StWait: begin
        if (stop_sign)  state_d = StDone;
        else if (due)   state_d = StEmit;
      end
      StEmit: begin
        if (accept) begin
          count_d = count_q + CountOne;
          if (addr_q == AddrMax) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_q + AddrOne;
            state_d = StFetch;
          end
        end
        // A handshake in the same cycle as stop still counts before stopping.
        if (stop_sign) state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    valid_d = (state_d == StEmit);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      lane_q  <= '0;
      time_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      time_q  <= time_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr    = addr_q;
  assign note_count  = count_q;
  assign spawn_lane  = lane_q;
  assign spawn_time  = time_q;
  assign spawn_valid = valid_q;
  assign chart_done  = done_q;

endmodule
